i2c_cfg_sequencer: RTL and testbench
====================================

# i2c_cfg_sequencer

Sequences the codec/microphone register-configuration writes over the shared byte-level I2C master. Walks an external configuration table of register/data pairs and issues one 3-byte I2C write per entry: device address, register, data. Sits between the top-level control (reset, push-button) and the I2C master that drives `scl`/`sda`. Reports busy, done and error status for the LED logic.

## Interface
- `NUM_ENTRIES`, 8: table length, 1..256.
- `DEV_ADDR`, 7'h1A: 7-bit I2C slave address. The write byte is `{DEV_ADDR,1'b0}`.
- `GAP_CYCLES`, 16: idle clocks between consecutive transactions, ≥1.
- `MAX_RETRY`, 3: retries per entry after NACK (used only with retry enabled).
- `AUTO_START`, 1: run the table once after reset release.

Ports:
- `clk`  in  1  system clock, 100 MHz.
- `rst_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  single-cycle request to run the table.
- `rom_addr`  out  8  table index, registered.
- `rom_data`  in  16  `{reg[15:8], data[7:0]}`, combinational from `rom_addr`.
- `cmd_valid`  out  1  byte command valid.
- `cmd_ready`  in  1  master accepts the command.
- `cmd_start`  out  1  master emits START before this byte.
- `cmd_stop`  out  1  master emits STOP after this byte.
- `cmd_data`  out  8  byte to send.
- `rsp_valid`  in  1  one-cycle pulse: byte finished, ACK sampled.
- `rsp_nack`  in  1  qualified by `rsp_valid`; 1 = NACK. On NACK the master has already issued STOP.
- `busy`  out  1  sequence in progress.
- `done`  out  1  level: last run completed with no error.
- `err`  out  1  level: last run aborted.
- `err_idx`  out  8  table index that failed.

## Operation
- States:
  - IDLE
  - LOAD
  - SEND_DEV / WAIT_DEV
  - SEND_REG / WAIT_REG
  - SEND_DAT / WAIT_DAT
  - GAP
  - FAIL
- Entering the run:
  - From IDLE, `start`, or the first cycle after reset when `AUTO_START=1`, clears `done`, `err`, `err_idx` and the index.
  - It also sets `busy` and goes to LOAD.
- LOAD: latch `rom_data` into internal reg/data registers (`rom_addr` has been stable ≥1 cycle). Clear the retry count on a new index. Go to SEND_DEV.
- SEND_DEV: `cmd_data={DEV_ADDR,0}`, `cmd_start=1`, `cmd_stop=0`.
- SEND_REG: reg byte, no start, no stop.
- SEND_DAT: data byte, `cmd_stop=1`.
- Each SEND_x state asserts `cmd_valid` until the `cmd_valid&cmd_ready` handshake, then goes to WAIT_x. `cmd_*` fields are stable while `cmd_valid` is high.
- WAIT_x: on `rsp_valid&!rsp_nack`, advance to the next SEND. After WAIT_DAT, go to GAP.
- WAIT_x on `rsp_valid&rsp_nack`:
  - if retries remain, increment the retry count, go to GAP, then re-run the same index;
  - otherwise go to FAIL.
- GAP: count `GAP_CYCLES`.
  - After a successful entry, increment the index. If it equals `NUM_ENTRIES`, go to IDLE with `done=1`, `busy=0`; otherwise go to LOAD.
- FAIL: one cycle. Sets `err=1`, `err_idx=index`, `busy=0`, then goes to IDLE.
- `start` while `busy` is ignored. `start` in the same cycle as FAIL→IDLE is ignored.
- `rsp_valid` outside a WAIT state is ignored.
- Index is 8 bits. `NUM_ENTRIES=256` terminates when the count wraps to 0 after the last entry.

## Timing
- Reset values:
  - state IDLE;
  - `rom_addr=0`, `cmd_valid=0`, `cmd_start=0`, `cmd_stop=0`, `cmd_data=0`;
  - `busy=0`, `done=0`, `err=0`, `err_idx=0`.
- Latency and cycle rules:
  - `start` at cycle N: `busy=1` at N+1, LOAD at N+1, `cmd_valid=1` at N+2.
  - `cmd_valid` deasserts the cycle after the handshake.
  - `rsp_valid` at cycle M advances state at M+1. The next `cmd_valid` (or GAP entry) is visible at M+1.
  - `rom_addr` updates on GAP exit. LOAD samples `rom_data` one cycle later.
  - `done`/`err` update on the same edge that `busy` falls.
- Reset mid-operation: everything returns to reset values immediately. The master must be reset by the same `rst_n`.
- `AUTO_START` triggers only once, on the first clock after `rst_n` deasserts.

## Configuration
- `I2C_CFG_RETRY_EN` defined: NACK retries the whole entry (DEV, REG, DAT) up to `MAX_RETRY` times, with GAP before each retry. FAIL occurs only after `MAX_RETRY+1` total NACKed attempts.
- Undefined: the retry counter is absent. The first NACK goes straight to FAIL; `MAX_RETRY` is ignored.

## Test plan
- Auto-start, `NUM_ENTRIES=2`, table `{16'h0217, 16'h0680}`, master always ACK and ready:
  - byte stream A 0x34 (start), 0x02, 0x17 (stop), then GAP ≥16 cycles, then 0x34, 0x06, 0x80;
  - `done=1`, `busy=0`, `err=0`.
- Back-pressure: `cmd_ready` low for 5 cycles on every byte → `cmd_valid`/`cmd_data` held stable; same byte stream as the first scenario.
- NACK on REG byte of entry 1:
  - with `I2C_CFG_RETRY_EN`, `MAX_RETRY=3`, NACK twice then ACK → entry 1 re-sent from 0x34, `done=1`;
  - without the macro → `err=1`, `err_idx=1`, `done=0`, and no further `cmd_valid`.
- Retry exhaustion (macro on, always NACK on DEV byte) → exactly 4 DEV attempts, then `err=1`, `err_idx=0`.
- `start` pulsed mid-run → ignored, byte count unchanged. `start` after `done` → new run, `done` clears at N+1.
- `rst_n` low during WAIT_REG → all outputs at reset values asynchronously. After release with `AUTO_START=1`, the run restarts at index 0.

Source files
------------

// File: rtl/i2c_cfg_sequencer.sv
// Walks a reg/data table and issues one 3-byte I2C write (dev, reg, data) per entry; cmd_valid two cycles after start, held until cmd_ready.
// Define I2C_CFG_RETRY_EN to retry a NACKed entry (after a GAP) up to MAX_RETRY times before flagging err.
module i2c_cfg_sequencer #(
   parameter int unsigned NUM_ENTRIES = 8,
   parameter logic [6:0]  DEV_ADDR    = 7'h1A,
   parameter int unsigned GAP_CYCLES  = 16,
   parameter int unsigned MAX_RETRY   = 3,
   parameter bit          AUTO_START  = 1'b1
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        start,
   output logic [7:0]  rom_addr,
   input  logic [15:0] rom_data,
   output logic        cmd_valid,
   input  logic        cmd_ready,
   output logic        cmd_start,
   output logic        cmd_stop,
   output logic [7:0]  cmd_data,
   input  logic        rsp_valid,
   input  logic        rsp_nack,
   output logic        busy,
   output logic        done,
   output logic        err,
   output logic [7:0]  err_idx
);

   typedef enum logic [3:0] {
      S_IDLE,
      S_LOAD,
      S_SEND_DEV,
      S_WAIT_DEV,
      S_SEND_REG,
      S_WAIT_REG,
      S_SEND_DAT,
      S_WAIT_DAT,
      S_GAP,
      S_FAIL
   } state_e;

   // Comparing against the last index lets NUM_ENTRIES=256 finish without a 9-bit counter.
   localparam logic [7:0] LAST_IDX = 8'(NUM_ENTRIES - 1);
   localparam int unsigned GW = (GAP_CYCLES < 2) ? 1 : $clog2(GAP_CYCLES);
   localparam logic [GW-1:0] GAP_LOAD = GW'(GAP_CYCLES - 1);

   state_e         state_q, state_d;
   logic [7:0]     idx_q, idx_d;
   logic [7:0]     reg_q, reg_d;
   logic [7:0]     dat_q, dat_d;
   logic [GW-1:0]  gap_q, gap_d;
   logic           busy_q, busy_d;
   logic           done_q, done_d;
   logic           err_q, err_d;
   logic [7:0]     err_idx_q, err_idx_d;
   logic           auto_q;
   logic           nack;
   logic           gap_ok;

`ifdef I2C_CFG_RETRY_EN
   localparam int unsigned RW = (MAX_RETRY < 2) ? 1 : $clog2(MAX_RETRY + 1);
   logic [RW-1:0]  retry_q, retry_d;
   logic           ok_q, ok_d;

   // ok_q distinguishes a completed entry from a retry pass through GAP.
   assign gap_ok = ok_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         retry_q <= '0;
         ok_q    <= 1'b0;
      end else begin
         retry_q <= retry_d;
         ok_q    <= ok_d;
      end
   end
`else
   assign gap_ok = 1'b1;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= S_IDLE;
         idx_q     <= '0;
         reg_q     <= '0;
         dat_q     <= '0;
         gap_q     <= '0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         err_q     <= 1'b0;
         err_idx_q <= '0;
         auto_q    <= AUTO_START;
      end else begin
         state_q   <= state_d;
         idx_q     <= idx_d;
         reg_q     <= reg_d;
         dat_q     <= dat_d;
         gap_q     <= gap_d;
         busy_q    <= busy_d;
         done_q    <= done_d;
         err_q     <= err_d;
         err_idx_q <= err_idx_d;
         auto_q    <= 1'b0;
      end
   end

   always_comb begin
      state_d   = state_q;
      idx_d     = idx_q;
      reg_d     = reg_q;
      dat_d     = dat_q;
      gap_d     = gap_q;
      busy_d    = busy_q;
      done_d    = done_q;
      err_d     = err_q;
      err_idx_d = err_idx_q;
      nack      = 1'b0;
      cmd_valid = 1'b0;
      cmd_start = 1'b0;
      cmd_stop  = 1'b0;
      cmd_data  = '0;
`ifdef I2C_CFG_RETRY_EN
      retry_d   = retry_q;
      ok_d      = ok_q;
`endif

      case (state_q)
         S_IDLE: begin
            if (start || auto_q) begin
               busy_d    = 1'b1;
               done_d    = 1'b0;
               err_d     = 1'b0;
               err_idx_d = '0;
               idx_d     = '0;
               state_d   = S_LOAD;
`ifdef I2C_CFG_RETRY_EN
               retry_d   = '0;
               ok_d      = 1'b0;
`endif
            end
         end
         S_LOAD: begin
            reg_d   = rom_data[15:8];
            dat_d   = rom_data[7:0];
            state_d = S_SEND_DEV;
         end
         S_SEND_DEV: begin
            cmd_valid = 1'b1;
            cmd_start = 1'b1;
            cmd_data  = {DEV_ADDR, 1'b0};
            if (cmd_ready) state_d = S_WAIT_DEV;
         end
         S_WAIT_DEV: begin
            if (rsp_valid) begin
               if (rsp_nack) nack = 1'b1;
               else          state_d = S_SEND_REG;
            end
         end
         S_SEND_REG: begin
            cmd_valid = 1'b1;
            cmd_data  = reg_q;
            if (cmd_ready) state_d = S_WAIT_REG;
         end
         S_WAIT_REG: begin
            if (rsp_valid) begin
               if (rsp_nack) nack = 1'b1;
               else          state_d = S_SEND_DAT;
            end
         end
         S_SEND_DAT: begin
            cmd_valid = 1'b1;
            cmd_stop  = 1'b1;
            cmd_data  = dat_q;
            if (cmd_ready) state_d = S_WAIT_DAT;
         end
         S_WAIT_DAT: begin
            if (rsp_valid) begin
               if (rsp_nack) begin
                  nack = 1'b1;
               end else begin
                  gap_d   = GAP_LOAD;
                  state_d = S_GAP;
`ifdef I2C_CFG_RETRY_EN
                  ok_d    = 1'b1;
`endif
               end
            end
         end
         S_GAP: begin
            if (gap_q != '0) begin
               gap_d = gap_q - GW'(1);
            end else if (!gap_ok) begin
               state_d = S_LOAD;
            end else if (idx_q == LAST_IDX) begin
               idx_d   = idx_q + 8'd1;
               busy_d  = 1'b0;
               done_d  = 1'b1;
               state_d = S_IDLE;
            end else begin
               idx_d   = idx_q + 8'd1;
               state_d = S_LOAD;
`ifdef I2C_CFG_RETRY_EN
               retry_d = '0;
               ok_d    = 1'b0;
`endif
            end
         end
         S_FAIL: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase

      if (nack) begin
`ifdef I2C_CFG_RETRY_EN
         if (retry_q < RW'(MAX_RETRY)) begin
            retry_d = retry_q + RW'(1);
            ok_d    = 1'b0;
            gap_d   = GAP_LOAD;
            state_d = S_GAP;
         end else begin
            busy_d    = 1'b0;
            err_d     = 1'b1;
            err_idx_d = idx_q;
            state_d   = S_FAIL;
         end
`else
         busy_d    = 1'b0;
         err_d     = 1'b1;
         err_idx_d = idx_q;
         state_d   = S_FAIL;
`endif
      end
   end

   assign rom_addr = idx_q;
   assign busy     = busy_q;
   assign done     = done_q;
   assign err      = err_q;
   assign err_idx  = err_idx_q;

endmodule

// File: tb/tb_i2c_cfg_sequencer.sv
// Directed bench for i2c_cfg_sequencer with a behavioural byte-level I2C master (stall, NACK injection, response latency).
module tb_i2c_cfg_sequencer;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        start;
   logic [7:0]  rom_addr;
   logic [15:0] rom_data;
   logic        cmd_valid;
   logic        cmd_ready;
   logic        cmd_start;
   logic        cmd_stop;
   logic [7:0]  cmd_data;
   logic        rsp_valid;
   logic        rsp_nack;
   logic        busy;
   logic        done;
   logic        err;
   logic [7:0]  err_idx;

   int tests_run    = 0;
   int tests_failed = 0;

   logic [15:0] tbl [2] = '{16'h0217, 16'h0680};

   // master model controls
   int stall_cfg  = 0;
   int rsp_lat    = 0;
   int nack_entry = 0;
   int nack_pos   = 0;
   int nack_left  = 0;
   int dev_cnt    = 0;
   int cyc        = 0;

   logic [17:0] rec_q [$];
   int          rec_cyc [$];
   logic [17:0] exp_q [$];

`ifdef I2C_CFG_RETRY_EN
   localparam int EXP_ATT = 4;
`else
   localparam int EXP_ATT = 1;
`endif

   always #5 clk = ~clk;

   assign rom_data = (rom_addr < 8'd2) ? tbl[rom_addr[0]] : 16'h0000;

   i2c_cfg_sequencer #(
      .NUM_ENTRIES (2),
      .DEV_ADDR    (7'h1A),
      .GAP_CYCLES  (16),
      .MAX_RETRY   (3),
      .AUTO_START  (1'b1)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .start     (start),
      .rom_addr  (rom_addr),
      .rom_data  (rom_data),
      .cmd_valid (cmd_valid),
      .cmd_ready (cmd_ready),
      .cmd_start (cmd_start),
      .cmd_stop  (cmd_stop),
      .cmd_data  (cmd_data),
      .rsp_valid (rsp_valid),
      .rsp_nack  (rsp_nack),
      .busy      (busy),
      .done      (done),
      .err       (err),
      .err_idx   (err_idx)
   );

   task automatic chk_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests_run++;
      if (obs !== exp) begin
         tests_failed++;
         $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
      end
   endtask

   // expected record: {rom_addr, cmd_start, cmd_stop, cmd_data}
   function automatic logic [17:0] mk(input int e, input int p);
      logic [15:0] t;
      t = tbl[e];
      case (p)
         0:       return {8'(e), 2'b10, 8'h34};
         1:       return {8'(e), 2'b00, t[15:8]};
         default: return {8'(e), 2'b01, t[7:0]};
      endcase
   endfunction

   task automatic push_entry(input int e, input int n);
      for (int p = 0; p < n; p++) exp_q.push_back(mk(e, p));
   endtask

   task automatic cmp_stream(input string tag);
      chk_eq({tag, "_len"}, rec_q.size(), exp_q.size());
      for (int i = 0; i < exp_q.size() && i < rec_q.size(); i++)
         chk_eq($sformatf("%s_b%0d", tag, i), 32'(rec_q[i]), 32'(exp_q[i]));
   endtask

   task automatic wait_idle(input string tag, input int budget);
      int n;
      n = 0;
      while (busy && n < budget) begin
         @(negedge clk);
         n++;
      end
      chk_eq({tag, "_idle"}, busy, 0);
   endtask

   task automatic pulse_start(input string tag);
      @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      chk_eq({tag, "_busy_n1"}, busy, 1);
      chk_eq({tag, "_done_n1"}, done, 0);
      chk_eq({tag, "_err_n1"}, err, 0);
      @(negedge clk);
      chk_eq({tag, "_vld_n2"}, cmd_valid, 1);
   endtask

   // Behavioural master: decisions are made at the negedge for the following posedge.
   initial begin
      int       stall_cnt;
      logic     hs_prev;
      logic     rsp_pend;
      logic     pend_nack;
      int       rsp_cnt;
      int       pos;
      logic [9:0] held;
      stall_cnt = 0;
      hs_prev   = 1'b0;
      rsp_pend  = 1'b0;
      pend_nack = 1'b0;
      rsp_cnt   = 0;
      held      = '0;
      cmd_ready = 1'b0;
      rsp_valid = 1'b0;
      rsp_nack  = 1'b0;
      forever begin
         @(negedge clk);
         cyc++;
         if (!rst_n) begin
            stall_cnt = 0;
            hs_prev   = 1'b0;
            rsp_pend  = 1'b0;
            cmd_ready = 1'b0;
            rsp_valid = 1'b0;
            rsp_nack  = 1'b0;
            continue;
         end
         if (hs_prev) chk_eq("valid_drop", cmd_valid, 0);
         hs_prev   = 1'b0;
         rsp_valid = 1'b0;
         rsp_nack  = 1'b0;
         if (rsp_pend) begin
            if (rsp_cnt == 0) begin
               rsp_valid = 1'b1;
               rsp_nack  = pend_nack;
               rsp_pend  = 1'b0;
            end else begin
               rsp_cnt--;
            end
         end
         if (cmd_valid) begin
            if (stall_cnt < stall_cfg) begin
               if (stall_cnt > 0) chk_eq("hold_stable", {cmd_start, cmd_stop, cmd_data}, held);
               else held = {cmd_start, cmd_stop, cmd_data};
               cmd_ready = 1'b0;
               stall_cnt++;
            end else begin
               if (stall_cfg > 0) chk_eq("hold_stable_hs", {cmd_start, cmd_stop, cmd_data}, held);
               cmd_ready = 1'b1;
               rec_q.push_back({rom_addr, cmd_start, cmd_stop, cmd_data});
               rec_cyc.push_back(cyc);
               pos = cmd_start ? 0 : (cmd_stop ? 2 : 1);
               if (cmd_start) dev_cnt++;
               pend_nack = 1'b0;
               if (nack_left > 0 && int'(rom_addr) == nack_entry && pos == nack_pos) begin
                  pend_nack = 1'b1;
                  nack_left--;
               end
               rsp_pend  = 1'b1;
               rsp_cnt   = rsp_lat;
               stall_cnt = 0;
               hs_prev   = 1'b1;
            end
         end else begin
            if (stall_cnt > 0) chk_eq("valid_hold", cmd_valid, 1);
            stall_cnt = 0;
            cmd_ready = 1'b0;
         end
      end
   end

   initial begin
      int n;
      rst_n = 1'b0;
      start = 1'b0;
      repeat (3) @(negedge clk);
      chk_eq("rst_busy", busy, 0);
      chk_eq("rst_done", done, 0);
      chk_eq("rst_err", err, 0);
      chk_eq("rst_err_idx", err_idx, 0);
      chk_eq("rst_rom_addr", rom_addr, 0);
      chk_eq("rst_cmd_valid", cmd_valid, 0);
      chk_eq("rst_cmd_start", cmd_start, 0);
      chk_eq("rst_cmd_stop", cmd_stop, 0);
      chk_eq("rst_cmd_data", cmd_data, 0);

      // auto-start after reset release, master always ready and ACKing
      rst_n = 1'b1;
      @(negedge clk);
      chk_eq("auto_busy_n1", busy, 1);
      chk_eq("auto_vld_n1", cmd_valid, 0);
      @(negedge clk);
      chk_eq("auto_vld_n2", cmd_valid, 1);
      chk_eq("auto_dev_byte", cmd_data, 8'h34);
      chk_eq("auto_dev_start", cmd_start, 1);
      wait_idle("s1", 400);
      exp_q.delete();
      push_entry(0, 3);
      push_entry(1, 3);
      cmp_stream("s1");
      // DAT handshake -> WAIT(1) -> GAP(16) -> LOAD(1) -> SEND(1) -> DEV handshake
      chk_eq("s1_gap", (rec_cyc.size() >= 4) ? (rec_cyc[3] - rec_cyc[2]) : -1, 19);
      chk_eq("s1_done", done, 1);
      chk_eq("s1_err", err, 0);

      // back-pressure: 5 stall cycles per byte; also start after done
      rec_q.delete();
      rec_cyc.delete();
      stall_cfg = 5;
      pulse_start("s2");
      wait_idle("s2", 800);
      cmp_stream("s2");
      chk_eq("s2_done", done, 1);
      stall_cfg = 0;

      // start pulsed mid-run is ignored
      rec_q.delete();
      pulse_start("s3");
      repeat (10) @(negedge clk);
      chk_eq("s3_busy_mid", busy, 1);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      wait_idle("s3", 400);
      cmp_stream("s3");
      chk_eq("s3_done", done, 1);

      // NACK on REG byte of entry 1
      rec_q.delete();
      nack_entry = 1;
      nack_pos   = 1;
      exp_q.delete();
      push_entry(0, 3);
      push_entry(1, 2);
`ifdef I2C_CFG_RETRY_EN
      nack_left = 2;
      push_entry(1, 2);
      push_entry(1, 3);
`else
      nack_left = 1;
`endif
      pulse_start("s4");
      wait_idle("s4", 800);
      repeat (30) @(negedge clk);
      cmp_stream("s4");
`ifdef I2C_CFG_RETRY_EN
      chk_eq("s4_done", done, 1);
      chk_eq("s4_err", err, 0);
`else
      chk_eq("s4_err", err, 1);
      chk_eq("s4_err_idx", err_idx, 1);
      chk_eq("s4_done", done, 0);
      chk_eq("s4_no_vld", cmd_valid, 0);
`endif
      nack_left = 0;

      // retry exhaustion: DEV byte of entry 0 always NACKed
      rec_q.delete();
      dev_cnt    = 0;
      nack_entry = 0;
      nack_pos   = 0;
      nack_left  = 100;
      pulse_start("s5");
      wait_idle("s5", 1000);
      chk_eq("s5_dev_attempts", dev_cnt, EXP_ATT);
      chk_eq("s5_err", err, 1);
      chk_eq("s5_err_idx", err_idx, 0);
      chk_eq("s5_done", done, 0);
      nack_left = 0;

      // asynchronous reset while in WAIT_REG, then auto-restart from index 0
      rec_q.delete();
      rsp_lat = 10;
      pulse_start("s6");
      n = 0;
      while (rec_q.size() < 2 && n < 100) begin
         @(negedge clk);
         n++;
      end
      chk_eq("s6_reg_sent", rec_q.size() >= 2, 1);
      @(negedge clk);
      chk_eq("s6_pre_busy", busy, 1);
      #2;
      rst_n = 1'b0;
      #1;
      chk_eq("s6_rst_busy", busy, 0);
      chk_eq("s6_rst_vld", cmd_valid, 0);
      chk_eq("s6_rst_data", cmd_data, 0);
      chk_eq("s6_rst_start", cmd_start, 0);
      chk_eq("s6_rst_rom_addr", rom_addr, 0);
      chk_eq("s6_rst_done", done, 0);
      chk_eq("s6_rst_err", err, 0);
      repeat (3) @(negedge clk);
      rsp_lat = 0;
      rec_q.delete();
      rst_n = 1'b1;
      @(negedge clk);
      chk_eq("s6_auto_busy", busy, 1);
      wait_idle("s6", 400);
      exp_q.delete();
      push_entry(0, 3);
      push_entry(1, 3);
      cmp_stream("s6");
      chk_eq("s6_done", done, 1);

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, want finish before 500000");
      $fatal(1);
   end

endmodule
